data_sram_resp: RTL and testbench

Responder side of the core's data SRAM port: it accepts `data_sram_*` requests issued by the execute stage and returns read data one cycle later. Requests below the MMIO window hit an on-chip byte-writable RAM. Requests inside the MMIO window hit a small register file: a free-running counter, a compare register, an LED register and a status register. A timer match drives the core's `int[5]` line.

---
 rtl/mmio_pkg.sv | 43 ++++
 rtl/spram_bytewe.sv | 47 ++++
 rtl/data_sram_resp.sv | 166 ++++++++++++++++
 tb/tb_data_sram_resp.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mmio_pkg
// Purpose  : Shared constants, types and helpers for the data SRAM responder
//            MMIO window (window select, register offsets, interrupt bit).
// Revision : 1.0 - initial release
// ============================================================================
package mmio_pkg;

  // Value of addr[31:16] that selects the MMIO register window.
  localparam logic [15:0] MMIO_HI = 16'hBFAF;

  // Register offsets inside the window (addr[15:0]).
  localparam logic [15:0] OFF_COUNT   = 16'h0000;
  localparam logic [15:0] OFF_COMPARE = 16'h0004;
  localparam logic [15:0] OFF_LED     = 16'h0008;
  localparam logic [15:0] OFF_STATUS  = 16'h000C;

  // Core interrupt line driven by the timer match.
  localparam int INT_TIMER_BIT = 5;

  // Which registered source currently drives the read-data port.
  typedef enum logic {
    RD_SRC_REG = 1'b0,
    RD_SRC_RAM = 1'b1
  } rd_src_e;

  // Replace only the byte lanes whose enable bit is set.
  function automatic logic [31:0] byte_merge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  be
  );
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spram_bytewe.sv
`default_nettype none
// ============================================================================
// Module   : spram_bytewe
// Purpose  : Single-port 2^ADDR_W x 32 RAM with four byte write enables and a
//            synchronous read port. The read register only updates on a read
//            access, so it holds across writes and idle cycles.
// Ports    : clk      - clock
//            i_en     - access valid
//            i_we     - byte write enables (0000 = read)
//            i_addr   - word index
//            i_wdata  - byte-lane aligned write data
//            o_rdata  - registered read data
// Revision : 1.0 - initial release
// ============================================================================
module spram_bytewe #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic [3:0]        i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  localparam int c_DEPTH = 1 << ADDR_W;

  logic [31:0] r_mem [c_DEPTH];
  logic [31:0] r_q;

  // Contents are deliberately not reset; the responder masks r_q after reset.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we == 4'b0000) begin
        r_q <= r_mem[i_addr];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  assign o_rdata = r_q;

endmodule
`default_nettype wire

// File: rtl/data_sram_resp.sv
`default_nettype none
// ============================================================================
// Module   : data_sram_resp
// Purpose  : Responder for the core's data SRAM port. Addresses whose upper
//            half equals MMIO_HI hit a small register file (free-running
//            COUNT, COMPARE, LED, STATUS); everything else hits an on-chip
//            byte-writable RAM that aliases on the unchecked upper bits.
//            Read data is returned one cycle after the request.
// Ports    : clk              - clock
//            rst              - synchronous active-high reset
//            data_sram_en     - request valid
//            data_sram_wen    - byte write enables (0000 = read)
//            data_sram_addr   - byte address (bits [1:0] ignored)
//            data_sram_wdata  - byte-lane aligned write data
//            data_sram_rdata  - read data, valid the cycle after a read
//            intr             - core interrupt lines int[5:0]; bit 5 is the
//                               timer pending flag (int is a reserved word)
//            led              - LED register bits [15:0]
// Revision : 1.0 - initial release
// ============================================================================
module data_sram_resp #(
  parameter int          ADDR_W  = 12,
  parameter logic [15:0] MMIO_HI = mmio_pkg::MMIO_HI
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [5:0]  intr,
  output logic [15:0] led
);

  import mmio_pkg::*;

  // --------------------------------------------------------------------------
  // Request decode (requests during reset are dropped)
  // --------------------------------------------------------------------------
  logic              w_mmio;
  logic [15:0]       w_off;
  logic [ADDR_W-1:0] w_widx;
  logic              w_rd;
  logic              w_wr;
  logic              w_unused_addr;

  assign w_mmio = (data_sram_addr[31:16] == MMIO_HI);
  assign w_off  = data_sram_addr[15:0];
  assign w_widx = data_sram_addr[ADDR_W+1:2];
  assign w_rd   = data_sram_en && (data_sram_wen == 4'b0000) && !rst;
  assign w_wr   = data_sram_en && (data_sram_wen != 4'b0000) && !rst;

  // Byte offset within a word is not used: accesses are word-wide with lanes.
  assign w_unused_addr = ^data_sram_addr[1:0];

  logic w_wr_count;
  logic w_wr_compare;
  logic w_wr_led;
  logic w_wr_status;

  assign w_wr_count   = w_wr && w_mmio && (w_off == OFF_COUNT);
  assign w_wr_compare = w_wr && w_mmio && (w_off == OFF_COMPARE);
  assign w_wr_led     = w_wr && w_mmio && (w_off == OFF_LED);
  assign w_wr_status  = w_wr && w_mmio && (w_off == OFF_STATUS);

  // --------------------------------------------------------------------------
  // RAM
  // --------------------------------------------------------------------------
  logic        w_ram_en;
  logic [31:0] w_ram_q;

  assign w_ram_en = (w_rd || w_wr) && !w_mmio;

  spram_bytewe #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_en    (w_ram_en),
    .i_we    (data_sram_wen),
    .i_addr  (w_widx),
    .i_wdata (data_sram_wdata),
    .o_rdata (w_ram_q)
  );

  // --------------------------------------------------------------------------
  // MMIO registers
  // --------------------------------------------------------------------------
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic [15:0] r_led;
  logic        r_pending;
  logic [31:0] r_reg_q;
  rd_src_e     r_rd_src;

  logic        w_match;
  logic        w_pend_clr;
  logic [31:0] w_reg_rdata;

  // Match uses the pre-edge COMPARE, so a COMPARE write in the match cycle
  // still lets the set win over its implicit clear.
  assign w_match    = (r_count == r_compare) && (r_compare != 32'h0);
  assign w_pend_clr = w_wr_compare ||
                      (w_wr_status && data_sram_wen[0] && data_sram_wdata[0]);

  always_comb begin
    w_reg_rdata = 32'h0;
    case (w_off)
      OFF_COUNT:   w_reg_rdata = r_count;
      OFF_COMPARE: w_reg_rdata = r_compare;
      OFF_LED:     w_reg_rdata = {16'h0, r_led};
      OFF_STATUS:  w_reg_rdata = {31'h0, r_pending};
      default:     w_reg_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count   <= 32'h0;
      r_compare <= 32'h0;
      r_led     <= 16'h0;
      r_pending <= 1'b0;
      r_reg_q   <= 32'h0;
      r_rd_src  <= RD_SRC_REG;
    end else begin
      // A COUNT write replaces this cycle's increment.
      if (w_wr_count) r_count <= byte_merge(r_count, data_sram_wdata, data_sram_wen);
      else            r_count <= r_count + 32'd1;

      if (w_wr_compare) r_compare <= byte_merge(r_compare, data_sram_wdata, data_sram_wen);

      if (w_wr_led) begin
        if (data_sram_wen[0]) r_led[7:0]  <= data_sram_wdata[7:0];
        if (data_sram_wen[1]) r_led[15:8] <= data_sram_wdata[15:8];
      end

      if (w_match)         r_pending <= 1'b1;
      else if (w_pend_clr) r_pending <= 1'b0;

      // Only reads move the source select; writes and idles leave both the
      // select and the selected register alone, so rdata holds.
      if (w_rd) begin
        if (w_mmio) begin
          r_rd_src <= RD_SRC_REG;
          r_reg_q  <= w_reg_rdata;
        end else begin
          r_rd_src <= RD_SRC_RAM;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (all driven straight from registers)
  // --------------------------------------------------------------------------
  assign data_sram_rdata = (r_rd_src == RD_SRC_RAM) ? w_ram_q : r_reg_q;

  always_comb begin
    intr                = 6'b0;
    intr[INT_TIMER_BIT] = r_pending;
  end

  assign led = r_led;

endmodule
`default_nettype wire

// File: tb/tb_data_sram_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_sram_resp
// Purpose  : Self-checking bench for data_sram_resp: a vector table for the
//            basic RAM/LED/hold behaviour, hand sequences for timer, wrap,
//            set/clear race and reset, then random traffic against a
//            behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_sram_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [5:0]  intr;
  logic [15:0] led;

  always #5 clk = ~clk;

  data_sram_resp #(
    .ADDR_W  (12),
    .MMIO_HI (16'hBFAF)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .data_sram_en    (en),
    .data_sram_wen   (wen),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .intr            (intr),
    .led             (led)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- behavioural model ----------------
  logic [31:0] m_ram [int];
  logic [31:0] m_count;
  logic [31:0] m_compare;
  logic [15:0] m_led;
  logic        m_pend;
  logic [31:0] m_rdata;
  bit          m_rd_known;

  function automatic logic [31:0] lane_merge(input logic [31:0] o, input logic [31:0] n,
                                             input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (o & ~mask) | (n & mask);
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic e, input logic [3:0] w,
                            input logic [31:0] a, input logic [31:0] d);
    logic        mmio, set, clr;
    logic [15:0] off;
    logic [31:0] nxt_count, t;
    int          idx;
    if (r) begin
      m_rdata = 0; m_rd_known = 1; m_count = 0; m_compare = 0; m_led = 0; m_pend = 0;
      return;
    end
    mmio = (a[31:16] == 16'hBFAF);
    off  = a[15:0];
    idx  = int'(a[13:2]);
    set  = (m_count == m_compare) && (m_compare != 0);
    clr  = 1'b0;
    nxt_count = m_count + 1;
    if (e && w == 4'h0) begin
      m_rd_known = 1;
      if (mmio) begin
        case (off)
          16'h0000: m_rdata = m_count;
          16'h0004: m_rdata = m_compare;
          16'h0008: m_rdata = {16'h0, m_led};
          16'h000C: m_rdata = {31'h0, m_pend};
          default:  m_rdata = 0;
        endcase
      end else if (m_ram.exists(idx)) begin
        m_rdata = m_ram[idx];
      end else begin
        m_rd_known = 0;
      end
    end else if (e) begin
      if (mmio) begin
        case (off)
          16'h0000: nxt_count = lane_merge(m_count, d, w);
          16'h0004: begin m_compare = lane_merge(m_compare, d, w); clr = 1'b1; end
          16'h0008: begin t = lane_merge({16'h0, m_led}, d, w); m_led = t[15:0]; end
          16'h000C: if (w[0] && d[0]) clr = 1'b1;
          default: ;
        endcase
      end else if (m_ram.exists(idx)) begin
        m_ram[idx] = lane_merge(m_ram[idx], d, w);
      end else if (w == 4'hF) begin
        m_ram[idx] = d;
      end
    end
    m_count = nxt_count;
    if (set)      m_pend = 1'b1;
    else if (clr) m_pend = 1'b0;
  endtask

  // Drive one request for one clock, advance the model, sample 1 after edge.
  task automatic step(input logic r, input logic e, input logic [3:0] w,
                      input logic [31:0] a, input logic [31:0] d);
    rst = r; en = e; wen = w; addr = a; wdata = d;
    model_edge(r, e, w, a, d);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    if (m_rd_known) check32({tag, " rdata"}, rdata, m_rdata);
    check32({tag, " int"}, {26'h0, intr}, {26'h0, m_pend, 5'h0});
    check32({tag, " led"}, {16'h0, led}, {16'h0, m_led});
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        r;
    logic        e;
    logic [3:0]  w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] x_rdata;
    logic [15:0] x_led;
  } vec_t;

  vec_t tbl [15];

  localparam logic [31:0] A_CNT = 32'hBFAF_0000;
  localparam logic [31:0] A_CMP = 32'hBFAF_0004;
  localparam logic [31:0] A_LED = 32'hBFAF_0008;
  localparam logic [31:0] A_STS = 32'hBFAF_000C;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          risen;
    int          sel;
    logic [31:0] a, d;
    logic [3:0]  w;
    logic [15:0] offs [6];

    rst = 1'b1; en = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check32("reset rdata", rdata, 32'h0);
    check32("reset int", {26'h0, intr}, 32'h0);
    check32("reset led", {16'h0, led}, 32'h0);

    //            r     e     w      addr          wdata          exp rdata      exp led
    tbl[0]  = '{1'b1, 1'b0, 4'h0, 32'h0,        32'h0,         32'h0,         16'h0};
    tbl[1]  = '{1'b0, 1'b1, 4'hF, 32'h0000_0010, 32'h1122_3344, 32'h0,         16'h0};
    tbl[2]  = '{1'b0, 1'b1, 4'h5, 32'h0000_0010, 32'hAABB_CCDD, 32'h0,         16'h0};
    tbl[3]  = '{1'b0, 1'b1, 4'h0, 32'h0000_0010, 32'h0,         32'h11BB_33DD, 16'h0};
    tbl[4]  = '{1'b0, 1'b1, 4'h0, 32'h0001_0010, 32'h0,         32'h11BB_33DD, 16'h0};
    tbl[5]  = '{1'b0, 1'b0, 4'h0, 32'h0,        32'h0,         32'h11BB_33DD, 16'h0};
    tbl[6]  = '{1'b0, 1'b1, 4'hF, A_LED,        32'h1234_ABCD, 32'h11BB_33DD, 16'hABCD};
    tbl[7]  = '{1'b0, 1'b1, 4'h0, A_LED,        32'h0,         32'h0000_ABCD, 16'hABCD};
    tbl[8]  = '{1'b0, 1'b1, 4'h0, 32'hBFAF_0020, 32'h0,         32'h0,         16'hABCD};
    tbl[9]  = '{1'b0, 1'b1, 4'h0, A_CNT,        32'h0,         32'h8,         16'hABCD};
    tbl[10] = '{1'b0, 1'b1, 4'h1, A_STS,        32'h1,         32'h8,         16'hABCD};
    tbl[11] = '{1'b0, 1'b1, 4'h0, A_STS,        32'h0,         32'h0,         16'hABCD};
    tbl[12] = '{1'b0, 1'b1, 4'h2, A_LED,        32'h0000_5500, 32'h0,         16'h55CD};
    tbl[13] = '{1'b0, 1'b1, 4'h0, A_LED,        32'h0,         32'h0000_55CD, 16'h55CD};
    tbl[14] = '{1'b1, 1'b1, 4'h0, 32'h0000_0010, 32'h0,         32'h0,         16'h0};

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].w, tbl[i].a, tbl[i].d);
      check32($sformatf("vec%0d rdata", i), rdata, tbl[i].x_rdata);
      check32($sformatf("vec%0d led", i), {16'h0, led}, {16'h0, tbl[i].x_led});
      check32($sformatf("vec%0d int", i), {26'h0, intr}, 32'h0);
    end

    // COUNT read three cycles after reset release
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, A_CNT, 0);
    check32("count after reset", rdata, 32'h3);

    // Timer match and clear
    step(0, 1, 4'hF, A_CMP, 32'h40);
    check_model("cmp write");
    risen = 0;
    for (int i = 0; i < 100 && !risen; i++) begin
      step(0, 0, 0, 0, 0);
      check_model("timer wait");
      risen = intr[5];
    end
    check32("timer rise", {31'h0, risen}, 32'h1);
    step(0, 1, 0, A_CNT, 0);
    check32("count at rise", rdata, 32'h41);
    step(0, 1, 4'h1, A_STS, 32'h1);
    check32("status clear", {26'h0, intr}, 32'h0);
    step(0, 1, 4'hF, A_CMP, 32'h0);
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 0, 0);
      check_model("cmp zero");
    end
    check32("no int cmp0", {26'h0, intr}, 32'h0);

    // Set and clear in the same cycle: set wins
    step(0, 1, 4'hF, A_CMP, m_count + 32'd3);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 4'h1, A_STS, 32'h1);
    check32("set beats clear", {31'h0, intr[5]}, 32'h1);
    step(0, 1, 4'h1, A_STS, 32'h1);
    check32("clear after race", {31'h0, intr[5]}, 32'h0);

    // COUNT wrap
    step(0, 1, 4'hF, A_CNT, 32'hFFFF_FFFE);
    step(0, 1, 0, A_CNT, 0);
    check32("wrap rd0", rdata, 32'hFFFF_FFFE);
    step(0, 1, 0, A_CNT, 0);
    check32("wrap rd1", rdata, 32'hFFFF_FFFF);
    step(0, 1, 0, A_CNT, 0);
    check32("wrap rd2", rdata, 32'h0);
    step(0, 1, 0, A_CNT, 0);
    check32("wrap rd3", rdata, 32'h1);

    // Reset in the middle of a read burst
    step(0, 1, 0, 32'h0000_0010, 0);
    step(0, 1, 0, 32'h0000_0010, 0);
    check32("burst rd", rdata, 32'h11BB_33DD);
    step(1, 1, 0, 32'h0000_0010, 0);
    check32("burst reset rdata", rdata, 32'h0);
    step(0, 1, 0, 32'h0000_0010, 0);
    check32("burst after reset", rdata, 32'h11BB_33DD);
    check_model("burst model");

    // Random traffic against the model
    for (int i = 0; i < 8; i++) step(0, 1, 4'hF, 32'(i * 4), $urandom);
    offs[0] = 16'h0000; offs[1] = 16'h0004; offs[2] = 16'h0008;
    offs[3] = 16'h000C; offs[4] = 16'h0020; offs[5] = 16'h0010;
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 5) a = {16'($urandom_range(0, 3)), 16'h0} |
                       32'($urandom_range(0, 7) * 4) | 32'($urandom_range(0, 3));
      else         a = {16'hBFAF, offs[$urandom_range(0, 5)]};
      w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      d = (a == A_CMP) ? m_count + 32'($urandom_range(1, 8)) : $urandom;
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 4) != 0), w, a, d);
      check_model($sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
